// File: rtl/matrix_scan_param.sv
// LED matrix row scanner: shifts one row of one bit plane, then latches it and holds
// output_enable for a binary-weighted time. `MATRIX_SCAN_FRAME_SYNC_EN adds a frame_start pulse.
module matrix_scan_param #(
  parameter int COLUMNS        = 64,
  parameter int ROW_ADDR_WIDTH = 4,
  parameter int BIT_DEPTH      = 6,
  parameter int OE_UNIT        = 1,
  parameter int BLANK_CYCLES   = 1
) (
  input  logic                        clk_in,
  input  logic                        reset,
  output logic [$clog2(COLUMNS)-1:0]  column_address,
  output logic [ROW_ADDR_WIDTH-1:0]   row_address,
  output logic [ROW_ADDR_WIDTH-1:0]   row_address_active,
  output logic [BIT_DEPTH-1:0]        brightness_mask,
  output logic [BIT_DEPTH-1:0]        brightness_mask_active,
  output logic                        clk_pixel,
  output logic                        row_latch,
  output logic                        output_enable
`ifdef MATRIX_SCAN_FRAME_SYNC_EN
  ,
  output logic                        frame_start
`endif
);

  // state      | meaning
  // ST_SHIFT   | clocking one row of one plane out, two clocks per column
  // ST_WAIT_OE | row shifted; waiting for OE window and blanking to finish
  // ST_LATCH   | one-clock latch strobe, OE forced low
  localparam logic [1:0] ST_SHIFT   = 2'd0;
  localparam logic [1:0] ST_WAIT_OE = 2'd1;
  localparam logic [1:0] ST_LATCH   = 2'd2;

  localparam int COL_W    = $clog2(COLUMNS);
  localparam int OE_MAX   = OE_UNIT << (BIT_DEPTH - 1);
  localparam int OE_CNT_W = $clog2(OE_MAX + 1);

  logic [1:0]                state_q, state_d;
  logic                      phase_q, phase_d;
  logic [COL_W-1:0]          col_q, col_d;
  logic [ROW_ADDR_WIDTH-1:0] row_q, row_d;
  logic [ROW_ADDR_WIDTH-1:0] row_act_q, row_act_d;
  logic [BIT_DEPTH-1:0]      mask_q, mask_d;
  logic [BIT_DEPTH-1:0]      mask_act_q, mask_act_d;
  logic [OE_CNT_W-1:0]       oe_cnt_q, oe_cnt_d;
  logic [OE_CNT_W-1:0]       oe_load;
  logic [3:0]                blank_cnt_q, blank_cnt_d;
  logic                      clk_pixel_q, clk_pixel_d;
  logic                      row_latch_q, row_latch_d;
  logic                      oe_q, oe_d;
  logic                      frame_start_q, frame_start_d;

  always_comb begin
    oe_load = '0;
    for (int i = 0; i < BIT_DEPTH; i++) begin
      if (mask_q[i]) oe_load = OE_CNT_W'(OE_UNIT) << i;
    end
  end

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    col_d      = col_q;
    row_d      = row_q;
    row_act_d  = row_act_q;
    mask_d     = mask_q;
    mask_act_d = mask_act_q;
    oe_cnt_d   = (oe_cnt_q != '0) ? oe_cnt_q - OE_CNT_W'(1) : '0;
    case (state_q)
      ST_SHIFT: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (col_q == '0) state_d = ST_WAIT_OE;
          else             col_d   = col_q - COL_W'(1);
        end
      end
      ST_WAIT_OE: begin
        if (oe_cnt_q == '0 && blank_cnt_q >= 4'(BLANK_CYCLES)) state_d = ST_LATCH;
      end
      ST_LATCH: begin
        state_d    = ST_SHIFT;
        phase_d    = 1'b0;
        col_d      = COL_W'(COLUMNS - 1);
        row_act_d  = row_q;
        mask_act_d = mask_q;
        oe_cnt_d   = oe_load;
        if (mask_q[BIT_DEPTH-1]) begin
          mask_d = BIT_DEPTH'(1);
          row_d  = row_q + ROW_ADDR_WIDTH'(1);
        end else begin
          mask_d = mask_q << 1;
        end
      end
      default: begin
        state_d = ST_SHIFT;
        phase_d = 1'b0;
      end
    endcase
    // Outputs are registered from next-state values so they line up with the state they describe.
    clk_pixel_d   = (state_d == ST_SHIFT) && phase_d;
    row_latch_d   = (state_d == ST_LATCH);
    oe_d          = (oe_cnt_d != '0);
    frame_start_d = (state_d == ST_LATCH) && (row_q == '1) && mask_q[BIT_DEPTH-1];
    if (oe_d)                   blank_cnt_d = '0;
    else if (blank_cnt_q == '1) blank_cnt_d = blank_cnt_q;
    else                        blank_cnt_d = blank_cnt_q + 4'd1;
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q       <= ST_SHIFT;
      phase_q       <= 1'b0;
      col_q         <= COL_W'(COLUMNS - 1);
      row_q         <= '0;
      row_act_q     <= '0;
      mask_q        <= BIT_DEPTH'(1);
      mask_act_q    <= '0;
      oe_cnt_q      <= '0;
      blank_cnt_q   <= '1;
      clk_pixel_q   <= 1'b0;
      row_latch_q   <= 1'b0;
      oe_q          <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      col_q         <= col_d;
      row_q         <= row_d;
      row_act_q     <= row_act_d;
      mask_q        <= mask_d;
      mask_act_q    <= mask_act_d;
      oe_cnt_q      <= oe_cnt_d;
      blank_cnt_q   <= blank_cnt_d;
      clk_pixel_q   <= clk_pixel_d;
      row_latch_q   <= row_latch_d;
      oe_q          <= oe_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign column_address         = col_q;
  assign row_address            = row_q;
  assign row_address_active     = row_act_q;
  assign brightness_mask        = mask_q;
  assign brightness_mask_active = mask_act_q;
  assign clk_pixel              = clk_pixel_q;
  assign row_latch              = row_latch_q;
  assign output_enable          = oe_q;
`ifdef MATRIX_SCAN_FRAME_SYNC_EN
  assign frame_start            = frame_start_q;
`else
  logic unused_frame_start;
  assign unused_frame_start = frame_start_q;
`endif

endmodule

// File: tb/tb_matrix_scan_param.sv
// Bench for matrix_scan_param: three configurations checked against a latch-timing scoreboard.
// Honours `MATRIX_SCAN_FRAME_SYNC_EN for the frame_start port.
module tb_matrix_scan_param;

  typedef struct {
    int t;
    int row;
    int mask;
    int fs;
    int oe;
  } lat_t;

  logic clk_in = 1'b0;
  logic reset  = 1'b1;
  always #5 clk_in = ~clk_in;

  // a: defaults; b: long OE windows with extra blanking; c: tiny frame for row wrap
  logic [5:0] a_col;  logic [3:0] a_row, a_row_act; logic [5:0] a_mask, a_mask_act;
  logic a_pix, a_rl, a_oe;
  logic [2:0] b_col;  logic [1:0] b_row, b_row_act; logic [5:0] b_mask, b_mask_act;
  logic b_pix, b_rl, b_oe;
  logic [1:0] c_col;  logic [1:0] c_row, c_row_act; logic [1:0] c_mask, c_mask_act;
  logic c_pix, c_rl, c_oe;
`ifdef MATRIX_SCAN_FRAME_SYNC_EN
  logic a_fs, b_fs, c_fs;
`endif

  matrix_scan_param u_a (
    .clk_in(clk_in), .reset(reset), .column_address(a_col), .row_address(a_row),
    .row_address_active(a_row_act), .brightness_mask(a_mask), .brightness_mask_active(a_mask_act),
    .clk_pixel(a_pix), .row_latch(a_rl), .output_enable(a_oe)
`ifdef MATRIX_SCAN_FRAME_SYNC_EN
    , .frame_start(a_fs)
`endif
  );

  matrix_scan_param #(.COLUMNS(8), .ROW_ADDR_WIDTH(2), .BIT_DEPTH(6), .OE_UNIT(8), .BLANK_CYCLES(3)) u_b (
    .clk_in(clk_in), .reset(reset), .column_address(b_col), .row_address(b_row),
    .row_address_active(b_row_act), .brightness_mask(b_mask), .brightness_mask_active(b_mask_act),
    .clk_pixel(b_pix), .row_latch(b_rl), .output_enable(b_oe)
`ifdef MATRIX_SCAN_FRAME_SYNC_EN
    , .frame_start(b_fs)
`endif
  );

  matrix_scan_param #(.COLUMNS(4), .ROW_ADDR_WIDTH(2), .BIT_DEPTH(2), .OE_UNIT(1), .BLANK_CYCLES(1)) u_c (
    .clk_in(clk_in), .reset(reset), .column_address(c_col), .row_address(c_row),
    .row_address_active(c_row_act), .brightness_mask(c_mask), .brightness_mask_active(c_mask_act),
    .clk_pixel(c_pix), .row_latch(c_rl), .output_enable(c_oe)
`ifdef MATRIX_SCAN_FRAME_SYNC_EN
    , .frame_start(c_fs)
`endif
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  lat_t q0[$];
  lat_t q1[$];
  lat_t q2[$];

  int cols_of[3] = '{64, 8, 4};
  int npix[3];
  int nlat[3];
  int oe_run[3];
  int exp_oe[3];
  int pend_row[3];
  int pend_mask[3];
  bit pend_act[3];
  bit pix_prev[3];
  bit oe_prev[3];

  task automatic check_val(input string tag, input int obs, input int exp);
    vectors++;
    if (obs != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push_exp(input int id, input lat_t e);
    case (id)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic pop_exp(input int id, output lat_t e, output bit ok);
    ok = 1'b0;
    e  = '{0, 0, 0, 0, 0};
    case (id)
      0: if (q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
      1: if (q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); ok = 1'b1; end
    endcase
  endtask

  // Latch schedule: a row takes 2*cols shift clocks + one WAIT_OE clock unless the
  // previous OE window (plus blanking) is still running.
  task automatic gen(input int id, input int cols, input int rw, input int bd,
                     input int ou, input int bl, input int n);
    int l;
    int row;
    int p;
    int nxt;
    lat_t e;
    l = 2 * cols + 1;
    row = 0;
    p = 0;
    for (int k = 0; k < n; k++) begin
      e.t    = l;
      e.row  = row;
      e.mask = 1 << p;
      e.fs   = (row == (1 << rw) - 1 && p == bd - 1) ? 1 : 0;
      e.oe   = ou << p;
      push_exp(id, e);
      nxt = l + 2 * cols + 2;
      if (l + e.oe + ((bl > 0) ? bl : 1) + 1 > nxt) nxt = l + e.oe + ((bl > 0) ? bl : 1) + 1;
      l = nxt;
      if (p == bd - 1) begin
        p = 0;
        row = (row + 1) % (1 << rw);
      end else begin
        p++;
      end
    end
  endtask

  task automatic mon(input int id, input int col, input int row, input int mask, input int row_act,
                     input int mask_act, input bit pix, input bit rl, input bit oe, input bit fs);
    lat_t e;
    bit ok;
    string nm;
    nm = $sformatf("inst%0d", id);
    if (pend_act[id]) begin
      check_val({nm, "_mask_active"}, mask_act, pend_mask[id]);
      check_val({nm, "_row_active"}, row_act, pend_row[id]);
      pend_act[id] = 1'b0;
    end
    if (pix && !pix_prev[id]) begin
      if (id == 0 && nlat[0] == 0) check_val({nm, "_column"}, col, cols_of[0] - 1 - npix[0]);
      npix[id]++;
    end
    if (rl) begin
      pop_exp(id, e, ok);
      if (ok) begin
        check_val({nm, "_latch_cycle"}, cyc, e.t);
        check_val({nm, "_latch_row"}, row, e.row);
        check_val({nm, "_latch_mask"}, mask, e.mask);
        check_val({nm, "_pixel_clocks"}, npix[id], cols_of[id]);
        check_val({nm, "_oe_pending"}, exp_oe[id], 0);
`ifdef MATRIX_SCAN_FRAME_SYNC_EN
        check_val({nm, "_frame_start"}, int'(fs), e.fs);
`endif
        pend_act[id]  = 1'b1;
        pend_mask[id] = e.mask;
        pend_row[id]  = e.row;
        exp_oe[id]    = e.oe;
        nlat[id]++;
      end
      npix[id] = 0;
    end
    if (oe) begin
      oe_run[id]++;
    end else if (oe_prev[id]) begin
      if (exp_oe[id] > 0) check_val({nm, "_oe_width"}, oe_run[id], exp_oe[id]);
      exp_oe[id] = 0;
      oe_run[id] = 0;
    end
    pix_prev[id] = pix;
    oe_prev[id]  = oe;
  endtask

  always @(posedge clk_in) cyc <= reset ? 0 : cyc + 1;

  always @(negedge clk_in) begin
    check_val("latch_oe_exclusive", int'((a_rl & a_oe) | (b_rl & b_oe) | (c_rl & c_oe)), 0);
  end

  always @(negedge clk_in) if (mon_en)
    mon(0, int'(a_col), int'(a_row), int'(a_mask), int'(a_row_act), int'(a_mask_act), a_pix, a_rl, a_oe,
`ifdef MATRIX_SCAN_FRAME_SYNC_EN
        a_fs
`else
        1'b0
`endif
    );

  always @(negedge clk_in) if (mon_en)
    mon(1, int'(b_col), int'(b_row), int'(b_mask), int'(b_row_act), int'(b_mask_act), b_pix, b_rl, b_oe,
`ifdef MATRIX_SCAN_FRAME_SYNC_EN
        b_fs
`else
        1'b0
`endif
    );

  always @(negedge clk_in) if (mon_en)
    mon(2, int'(c_col), int'(c_row), int'(c_mask), int'(c_row_act), int'(c_mask_act), c_pix, c_rl, c_oe,
`ifdef MATRIX_SCAN_FRAME_SYNC_EN
        c_fs
`else
        1'b0
`endif
    );

  initial begin
    int i;
    reset = 1'b1;
    repeat (3) @(negedge clk_in);
    check_val("rst_column", int'(a_col), 63);
    check_val("rst_row", int'(a_row), 0);
    check_val("rst_row_active", int'(a_row_act), 0);
    check_val("rst_mask", int'(a_mask), 1);
    check_val("rst_mask_active", int'(a_mask_act), 0);
    check_val("rst_clk_pixel", int'(a_pix), 0);
    check_val("rst_row_latch", int'(a_rl), 0);
    check_val("rst_oe", int'(a_oe), 0);
`ifdef MATRIX_SCAN_FRAME_SYNC_EN
    check_val("rst_frame_start", int'(c_fs), 0);
`endif

    gen(0, 64, 4, 6, 1, 1, 12);
    gen(1, 8, 2, 6, 8, 3, 7);
    gen(2, 4, 2, 2, 1, 1, 10);
    mon_en = 1'b1;
    reset  = 1'b0;

    i = 0;
    while (i < 4000 && (q0.size() + q1.size() + q2.size()) > 0) begin
      @(negedge clk_in);
      i++;
    end
    check_val("scoreboard_drained", q0.size() + q1.size() + q2.size(), 0);
    repeat (300) @(negedge clk_in);
    mon_en = 1'b0;

    // Reset in the middle of the 16-clock OE window of plane 4.
    i = 0;
    while (i < 2000 && !(a_mask_act == 6'd16 && a_oe)) begin
      @(negedge clk_in);
      i++;
    end
    check_val("found_plane4_oe", int'(a_mask_act == 6'd16 && a_oe), 1);
    repeat (5) @(negedge clk_in);
    check_val("oe_before_reset", int'(a_oe), 1);
    reset = 1'b1;
    @(negedge clk_in);
    check_val("midrst_oe", int'(a_oe), 0);
    check_val("midrst_row", int'(a_row), 0);
    check_val("midrst_mask", int'(a_mask), 1);
    check_val("midrst_column", int'(a_col), 63);
    check_val("midrst_mask_active", int'(a_mask_act), 0);
    check_val("midrst_row_latch", int'(a_rl), 0);
    reset = 1'b0;
    repeat (20) @(negedge clk_in);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
